// File: rtl/gfx_pkg.sv
// Shared graphics definitions: draw-mode encodings and the circle FSM state
// encoding, also intended for use by the ellipse rasteriser.
package gfx_pkg;

    // Draw modes, latched when a shape starts
    localparam logic DRAW_OUTLINE = 1'b0;
    localparam logic DRAW_FILL    = 1'b1;

    // Circle FSM state encoding
    localparam logic [2:0] CIRC_IDLE   = 3'd0;
    localparam logic [2:0] CIRC_CALC_Y = 3'd1;
    localparam logic [2:0] CIRC_CALC_X = 3'd2;
    localparam logic [2:0] CIRC_EMIT   = 3'd3;
    localparam logic [2:0] CIRC_DONE   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = CIRC_IDLE,
        ST_CALC_Y = CIRC_CALC_Y,
        ST_CALC_X = CIRC_CALC_X,
        ST_EMIT   = CIRC_EMIT,
        ST_DONE   = CIRC_DONE
    } circ_state_e;

endpackage

// File: rtl/circle_step.sv
// Midpoint circle stepper. Holds the quadrant point (xa, ya) and the error
// terms. A "next" request performs the y half-step; the x half-step follows
// on the next cycle, during which step_valid is high. "last" flags that the
// sweep has reached xa == 0 and no further step will be taken.
module circle_step
    import gfx_pkg::*;
#(
    parameter int CORDW = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic signed [CORDW-1:0] r0_i,
    input  logic                    next_i,
    output logic                    step_valid_o,
    output logic                    last_o,
    output logic signed [CORDW-1:0] xa_o,
    output logic signed [CORDW-1:0] ya_o,
    output logic signed [CORDW-1:0] xa_nxt_o,
    output logic signed [CORDW-1:0] ya_nxt_o
);

    localparam int EW = CORDW + 2;
    localparam logic signed [EW-1:0]    E_ONE = EW'(32'sd1);
    localparam logic signed [EW-1:0]    E_TWO = EW'(32'sd2);
    localparam logic signed [CORDW-1:0] C_ONE = CORDW'(32'sd1);

    logic signed [CORDW-1:0] xa_q, xa_d;
    logic signed [CORDW-1:0] ya_q, ya_d;
    logic signed [EW-1:0]    err_q, err_d;
    logic signed [EW-1:0]    err_tmp_q, err_tmp_d;
    logic                    phase_q, phase_d;   // 1: x half-step pending

    logic signed [EW-1:0]    xa_ext_s;
    logic signed [EW-1:0]    ya_ext_s;
    logic signed [EW-1:0]    r0_ext_s;
    logic                    last_s;

    assign xa_ext_s = {{2{xa_q[CORDW-1]}}, xa_q};
    assign ya_ext_s = {{2{ya_q[CORDW-1]}}, ya_q};
    assign r0_ext_s = {{2{r0_i[CORDW-1]}}, r0_i};
    assign last_s   = (xa_q == {CORDW{1'b0}});

    // Next-state for the point and error terms: load, y half-step, x half-step
    always_comb begin
        xa_d      = xa_q;
        ya_d      = ya_q;
        err_d     = err_q;
        err_tmp_d = err_tmp_q;
        phase_d   = 1'b0;
        if (load_i) begin
            xa_d      = -r0_i;
            ya_d      = {CORDW{1'b0}};
            err_d     = E_TWO - (r0_ext_s <<< 1);
            err_tmp_d = {EW{1'b0}};
        end else if (phase_q) begin
            // x half-step compares the y-updated err/ya with the saved err
            if ((err_tmp_q > xa_ext_s) || (err_q > ya_ext_s)) begin
                xa_d  = xa_q + C_ONE;
                err_d = err_q + ((xa_ext_s + E_ONE) <<< 1) + E_ONE;
            end else begin
                xa_d  = xa_q;
            end
        end else if (next_i && !last_s) begin
            err_tmp_d = err_q;
            phase_d   = 1'b1;
            if (err_q <= ya_ext_s) begin
                ya_d  = ya_q + C_ONE;
                err_d = err_q + ((ya_ext_s + E_ONE) <<< 1) + E_ONE;
            end else begin
                ya_d  = ya_q;
            end
        end else begin
            phase_d = 1'b0;
        end
    end

    // Stepper state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xa_q      <= {CORDW{1'b0}};
            ya_q      <= {CORDW{1'b0}};
            err_q     <= {EW{1'b0}};
            err_tmp_q <= {EW{1'b0}};
            phase_q   <= 1'b0;
        end else begin
            xa_q      <= xa_d;
            ya_q      <= ya_d;
            err_q     <= err_d;
            err_tmp_q <= err_tmp_d;
            phase_q   <= phase_d;
        end
    end

    assign step_valid_o = phase_q;
    assign last_o       = last_s;
    assign xa_o         = xa_q;
    assign ya_o         = ya_q;
    assign xa_nxt_o     = xa_d;
    assign ya_nxt_o     = ya_d;

endmodule

// File: rtl/circle_draw.sv
// Midpoint circle rasteriser. Emits four symmetric outline pixels or two
// horizontal fill spans per midpoint step, paced by the oe handshake.
// Output coordinates wrap modulo 2^CORDW.
module circle_draw
    import gfx_pkg::*;
#(
    parameter int CORDW = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    oe,
    input  logic                    mode,
    input  logic signed [CORDW-1:0] x0,
    input  logic signed [CORDW-1:0] y0,
    input  logic signed [CORDW-1:0] r0,
    output logic signed [CORDW-1:0] x,
    output logic signed [CORDW-1:0] y,
    output logic signed [CORDW-1:0] x_end,
    output logic                    busy,
    output logic                    valid,
    output logic                    done
);

    circ_state_e             state_q;
    logic [1:0]              idx_q;
    logic                    mode_q;
    logic signed [CORDW-1:0] x0_q, y0_q;
    logic signed [CORDW-1:0] x_q, y_q, xe_q;
    logic                    busy_q, valid_q, done_q;

    logic                    load_s, next_s;
    logic                    step_valid_s, step_last_s;
    logic signed [CORDW-1:0] xa_s, ya_s, xa_nxt_s, ya_nxt_s;
    logic signed [CORDW-1:0] neg_r0_s;
    logic [1:0]              idx_inc_s, last_idx_s;
    logic [3*CORDW-1:0]      map_start_s, map_next_s, map_step_s;

    // Map a quadrant point and symmetry index to {x, y, x_end}
    function automatic logic [3*CORDW-1:0] map_out(
        input logic                    md,
        input logic [1:0]              ix,
        input logic signed [CORDW-1:0] cx,
        input logic signed [CORDW-1:0] cy,
        input logic signed [CORDW-1:0] ax,
        input logic signed [CORDW-1:0] ay
    );
        logic signed [CORDW-1:0] px, py, pe;
        px = cx;
        py = cy;
        pe = cx;
        if (md == DRAW_FILL) begin
            px = cx + ax;
            pe = cx - ax;
            if (ix[0]) py = cy - ay;
            else       py = cy + ay;
        end else begin
            case (ix)
                2'd0:    begin px = cx - ax; py = cy + ay; end
                2'd1:    begin px = cx - ay; py = cy - ax; end
                2'd2:    begin px = cx + ax; py = cy - ay; end
                default: begin px = cx + ay; py = cy + ax; end
            endcase
            pe = px;
        end
        return {px, py, pe};
    endfunction

    assign load_s     = (state_q == ST_IDLE) && start && !r0[CORDW-1];
    assign next_s     = (state_q == ST_CALC_Y);
    assign neg_r0_s   = -r0;
    assign idx_inc_s  = idx_q + 2'd1;
    assign last_idx_s = (mode_q == DRAW_FILL) ? 2'd1 : 2'd3;

    circle_step #(.CORDW(CORDW)) u_step (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (load_s),
        .r0_i         (r0),
        .next_i       (next_s),
        .step_valid_o (step_valid_s),
        .last_o       (step_last_s),
        .xa_o         (xa_s),
        .ya_o         (ya_s),
        .xa_nxt_o     (xa_nxt_s),
        .ya_nxt_o     (ya_nxt_s)
    );

    // Candidate output words: first point of a circle, next index, next step
    always_comb begin
        map_start_s = map_out(mode, 2'd0, x0, y0, neg_r0_s, {CORDW{1'b0}});
        map_next_s  = map_out(mode_q, idx_inc_s, x0_q, y0_q, xa_s, ya_s);
        map_step_s  = map_out(mode_q, 2'd0, x0_q, y0_q, xa_nxt_s, ya_nxt_s);
    end

    // Control FSM with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= 2'd0;
            mode_q  <= DRAW_OUTLINE;
            x0_q    <= {CORDW{1'b0}};
            y0_q    <= {CORDW{1'b0}};
            x_q     <= {CORDW{1'b0}};
            y_q     <= {CORDW{1'b0}};
            xe_q    <= {CORDW{1'b0}};
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q <= mode;
                        x0_q   <= x0;
                        y0_q   <= y0;
                        busy_q <= 1'b1;
                        idx_q  <= 2'd0;
                        if (r0[CORDW-1]) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            {x_q, y_q, xe_q} <= map_start_s;
                            valid_q <= 1'b1;
                            state_q <= ST_EMIT;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_EMIT: begin
                    if (oe) begin
                        if (idx_q == last_idx_s) begin
                            valid_q <= 1'b0;
                            state_q <= ST_CALC_Y;
                        end else begin
                            idx_q <= idx_inc_s;
                            {x_q, y_q, xe_q} <= map_next_s;
                        end
                    end else begin
                        state_q <= ST_EMIT;
                    end
                end
                ST_CALC_Y: begin
                    if (step_last_s) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_CALC_X;
                    end
                end
                ST_CALC_X: begin
                    if (step_valid_s) begin
                        idx_q   <= 2'd0;
                        {x_q, y_q, xe_q} <= map_step_s;
                        valid_q <= 1'b1;
                        state_q <= ST_EMIT;
                    end else begin
                        state_q <= ST_CALC_X;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign x_end = xe_q;
    assign busy  = busy_q;
    assign valid = valid_q;
    assign done  = done_q;

endmodule

// File: tb/tb_circle_draw.sv
// Scoreboard bench for circle_draw: stimulus pushes hand-computed outputs
// (with their cycle offset from the start edge); a negedge monitor pops and
// compares on every accepted output.
module tb_circle_draw;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               oe = 1'b1;
    logic               mode = 1'b0;
    logic signed [15:0] x0 = 16'sd0, y0 = 16'sd0, r0 = 16'sd0;
    logic signed [15:0] x, y, x_end;
    logic               busy, valid, done;

    typedef struct {
        logic signed [15:0] ex;
        logic signed [15:0] ey;
        logic signed [15:0] exe;
        int                 ecyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   start_cyc = 0;

    circle_draw #(.CORDW(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .oe    (oe),
        .mode  (mode),
        .x0    (x0),
        .y0    (y0),
        .r0    (r0),
        .x     (x),
        .y     (y),
        .x_end (x_end),
        .busy  (busy),
        .valid (valid),
        .done  (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every accepted output against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && valid && oe) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output: got x=%0d y=%0d xe=%0d at rel cycle %0d, expected none",
                         x, y, x_end, cyc - start_cyc + 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (x !== e.ex || y !== e.ey || x_end !== e.exe || (cyc - start_cyc + 1) != e.ecyc) begin
                    failures++;
                    $display("FAIL output: got x=%0d y=%0d xe=%0d rel=%0d, expected x=%0d y=%0d xe=%0d rel=%0d",
                             x, y, x_end, cyc - start_cyc + 1, e.ex, e.ey, e.exe, e.ecyc);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic push(input logic signed [15:0] px, input logic signed [15:0] py,
                        input logic signed [15:0] pe, input int c);
        exp_t e;
        e.ex = px; e.ey = py; e.exe = pe; e.ecyc = c;
        sb.push_back(e);
    endtask

    // Outline r0=1: relative pixels for both steps; stall delays outputs 2..8
    task automatic push_outline_r1(input logic signed [15:0] cx, input logic signed [15:0] cy,
                                   input int stall);
        int dxs[8] = '{1, 0, -1, 0, 0, -1, 0, 1};
        int dys[8] = '{0, 1, 0, -1, 1, 0, -1, 0};
        int cs[8]  = '{1, 2, 3, 4, 7, 8, 9, 10};
        for (int i = 0; i < 8; i++) begin
            logic signed [15:0] px, py;
            px = cx + 16'(dxs[i]);
            py = cy + 16'(dys[i]);
            push(px, py, px, cs[i] + ((i > 0) ? stall : 0));
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of relative cycle 1
    task automatic start_circle(input logic md, input logic signed [15:0] cx,
                                input logic signed [15:0] cy, input logic signed [15:0] r);
        mode = md; x0 = cx; y0 = cy; r0 = r; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // Bounded wait for done; checks its cycle, drained scoreboard, and clean end
    task automatic wait_done(input string name, input int exp_rel);
        int n;
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        if (n >= 300) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got no done, expected done at rel %0d", name, exp_rel);
        end else begin
            check({name, "_done_cycle"}, 64'(cyc - start_cyc + 1), 64'(exp_rel));
            check({name, "_busy_at_done"}, 64'(busy), 64'd1);
            check({name, "_sb_drained"}, 64'(sb.size()), 64'd0);
            @(negedge clk);
            check({name, "_after_done"}, {62'd0, busy, done}, 64'd0);
        end
        @(posedge clk); #1;
        sb.delete();
    endtask

    initial begin
        // Reset state
        #12;
        check("reset_outputs", {x, y, x_end, 13'd0, busy, valid, done}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: outline r0=0 at (10,10)
        for (int i = 1; i <= 4; i++) push(16'sd10, 16'sd10, 16'sd10, i);
        start_circle(1'b0, 16'sd10, 16'sd10, 16'sd0);
        wait_done("s1_r0", 6);

        // 2: outline r0=1 at origin
        push_outline_r1(16'sd0, 16'sd0, 0);
        start_circle(1'b0, 16'sd0, 16'sd0, 16'sd1);
        wait_done("s2_outline_r1", 12);

        // 3: fill r0=1 at origin
        push(-16'sd1, 16'sd0, 16'sd1, 1);
        push(-16'sd1, 16'sd0, 16'sd1, 2);
        push(16'sd0, 16'sd1, 16'sd0, 5);
        push(16'sd0, -16'sd1, 16'sd0, 6);
        start_circle(1'b1, 16'sd0, 16'sd0, 16'sd1);
        wait_done("s3_fill_r1", 8);

        // Fill r0=2 at (100,-50)
        push(16'sd98, -16'sd50, 16'sd102, 1);
        push(16'sd98, -16'sd50, 16'sd102, 2);
        push(16'sd98, -16'sd49, 16'sd102, 5);
        push(16'sd98, -16'sd51, 16'sd102, 6);
        push(16'sd99, -16'sd48, 16'sd101, 9);
        push(16'sd99, -16'sd52, 16'sd101, 10);
        push(16'sd100, -16'sd48, 16'sd100, 13);
        push(16'sd100, -16'sd52, 16'sd100, 14);
        start_circle(1'b1, 16'sd100, -16'sd50, 16'sd2);
        wait_done("fill_r2", 16);

        // Wrap-around: outline r0=1 at (32767,-32768)
        push_outline_r1(16'sd32767, -16'sd32768, 0);
        start_circle(1'b0, 16'sd32767, -16'sd32768, 16'sd1);
        wait_done("wrap_r1", 12);

        // 4: oe low for 5 cycles while the second output is presented
        push_outline_r1(16'sd0, 16'sd0, 5);
        start_circle(1'b0, 16'sd0, 16'sd0, 16'sd1);
        @(posedge clk); #1;
        oe = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s4_stall_hold", {47'd0, valid, x, y}, {47'd0, 1'b1, 16'sd0, 16'sd1});
            @(posedge clk); #1;
        end
        oe = 1'b1;
        wait_done("s4_stall", 17);

        // 5a: start re-asserted while busy is ignored
        push_outline_r1(16'sd5, -16'sd3, 0);
        start_circle(1'b0, 16'sd5, -16'sd3, 16'sd1);
        @(posedge clk); #1;
        mode = 1'b1; r0 = 16'sd7; x0 = 16'sd40; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("s5_restart_ignored", 12);

        // 5b: negative radius -> no output, immediate done
        start_circle(1'b0, 16'sd0, 16'sd0, -16'sd3);
        wait_done("s5_neg_radius", 1);

        // 6: asynchronous reset in the middle of a r0=20 circle
        oe = 1'b0;
        start_circle(1'b0, 16'sd0, 16'sd0, 16'sd20);
        @(negedge clk);
        check("s6_first_held", {31'd0, busy, valid, x, y}, {31'd0, 1'b1, 1'b1, 16'sd20, 16'sd0});
        #2;
        rst_n = 1'b0;
        #1;
        check("s6_async_reset", {x, y, x_end, 13'd0, busy, valid, done}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        oe = 1'b1;
        @(posedge clk); #1;
        push_outline_r1(16'sd0, 16'sd0, 0);
        start_circle(1'b0, 16'sd0, 16'sd0, 16'sd1);
        wait_done("s6_after_reset", 12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
